// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier op encodings, multiplier FSM states and
// the datapath width.
package alu_pkg;

   localparam int XLEN      = 32;
   localparam int MUL_CNT_W = 6;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_CALC = 2'b01,
      MUL_FIX  = 2'b10,
      MUL_DONE = 2'b11
   } mul_state_e;

   // rs1 is signed for MULH and MULHSU; rs2 only for MULH.
   function automatic logic mul_a_signed(input mul_op_e op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   function automatic logic mul_b_signed(input mul_op_e op);
      return (op == MUL_OP_MULH);
   endfunction

endpackage

// File: rtl/add32_cla.sv
// 32-bit adder built from two 16-bit carry-lookahead blocks; the carry
// ripples between the halves and the carry-out forms bit 32 of the sum.
module cla16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);

   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   always_comb begin
      p  = x ^ y;
      g  = x & y;
      gg = '0;
      gp = '0;
      gc = '0;
      c  = '0;
      // Group generate/propagate for each 4-bit slice.
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc[0] = cin;
      for (int j = 0; j < 4; j++) begin
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      for (int j = 0; j < 4; j++) begin
         c[4*j] = gc[j];
         for (int k = 1; k < 4; k++) begin
            c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
         end
      end
      s    = p ^ c;
      cout = gc[4];
   end

endmodule

module add32_cla (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        cin,
   output logic [32:0] sum
);

   logic        carry_mid;
   logic        carry_out;
   logic [15:0] s_lo;
   logic [15:0] s_hi;

   cla16 u_cla_lo (
      .x    (x[15:0]),
      .y    (y[15:0]),
      .cin  (cin),
      .s    (s_lo),
      .cout (carry_mid)
   );

   cla16 u_cla_hi (
      .x    (x[31:16]),
      .y    (y[31:16]),
      .cin  (carry_mid),
      .s    (s_hi),
      .cout (carry_out)
   );

   assign sum = {carry_out, s_hi, s_lo};

endmodule

// File: rtl/mul_iter_32.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU:
// 32 add/shift cycles on operand magnitudes, then one sign-fix cycle.
module mul_iter_32
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   mul_state_e      state_q, state_d;
   mul_op_e         op_q, op_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] a_mag_q, a_mag_d;
   logic [XLEN-1:0] acc_hi_q, acc_hi_d;
   logic [XLEN-1:0] mplr_q, mplr_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;

   mul_op_e         op_in;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag_in;
   logic [XLEN-1:0] b_mag_in;

   logic            in_fix;
   logic [XLEN-1:0] add_lo_x;
   logic [XLEN-1:0] add_lo_y;
   logic [XLEN-1:0] add_hi_x;
   logic [XLEN-1:0] add_zero;
   logic [XLEN:0]   add_lo_sum;
   logic [XLEN:0]   add_hi_sum;
   logic            unused_hi_carry;
   logic [XLEN-1:0] p_lo;
   logic [XLEN-1:0] p_hi;

   assign op_in    = mul_op_e'(op);
   assign a_neg    = mul_a_signed(op_in) & a[XLEN-1];
   assign b_neg    = mul_b_signed(op_in) & b[XLEN-1];
   assign a_mag_in = a_neg ? (~a + XLEN'(1)) : a;
   assign b_mag_in = b_neg ? (~b + XLEN'(1)) : b;

   // The low adder accumulates in CALC; in FIX it and the high adder form
   // the 64-bit two's-complement negation as one carry chain.
   assign in_fix   = (state_q == MUL_FIX);
   assign add_zero = '0;
   assign add_lo_x = in_fix ? ~mplr_q : acc_hi_q;
   assign add_lo_y = (!in_fix && mplr_q[0]) ? a_mag_q : '0;
   assign add_hi_x = ~acc_hi_q;

   add32_cla u_add_lo (
      .x   (add_lo_x),
      .y   (add_lo_y),
      .cin (in_fix),
      .sum (add_lo_sum)
   );

   add32_cla u_add_hi (
      .x   (add_hi_x),
      .y   (add_zero),
      .cin (add_lo_sum[XLEN]),
      .sum (add_hi_sum)
   );

   assign unused_hi_carry = add_hi_sum[XLEN];
   assign p_lo = neg_q ? add_lo_sum[XLEN-1:0] : mplr_q;
   assign p_hi = neg_q ? add_hi_sum[XLEN-1:0] : acc_hi_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      neg_d       = neg_q;
      a_mag_d     = a_mag_q;
      acc_hi_d    = acc_hi_q;
      mplr_d      = mplr_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;

      case (state_q)
         MUL_IDLE: begin
            if (in_valid) begin
               op_d     = op_in;
               neg_d    = a_neg ^ b_neg;
               a_mag_d  = a_mag_in;
               acc_hi_d = '0;
               mplr_d   = b_mag_in;
               cnt_d    = '0;
               state_d  = MUL_CALC;
            end
         end
         MUL_CALC: begin
            // The 33-bit sum shifted right by one always fits in 32 bits.
            acc_hi_d = add_lo_sum[XLEN:1];
            mplr_d   = {add_lo_sum[0], mplr_q[XLEN-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_d = MUL_FIX;
            end
         end
         MUL_FIX: begin
            result_d = (op_q == MUL_OP_MUL) ? p_lo : p_hi;
            state_d  = MUL_DONE;
         end
         MUL_DONE: begin
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase

      if (flush) begin
         state_d     = MUL_IDLE;
         out_valid_d = 1'b0;
      end

      busy_d = (state_d != MUL_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= MUL_IDLE;
         op_q        <= MUL_OP_MUL;
         neg_q       <= 1'b0;
         a_mag_q     <= '0;
         acc_hi_q    <= '0;
         mplr_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         a_mag_q     <= a_mag_d;
         acc_hi_q    <= acc_hi_d;
         mplr_q      <= mplr_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = (state_q == MUL_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mul_iter_32.sv
// Self-checking bench for mul_iter_32: wide-integer reference model plus a
// per-cycle compare process on out_valid, result, busy and in_ready.
module tb_mul_iter_32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state, updated by the driver right after each active edge.
   logic        mon_en = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_ov   = 1'b0;
   logic [31:0] m_res  = '0;

   always #5 clk = ~clk;

   mul_iter_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Full-width signed product of the operands interpreted per op.
   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic        sx;
      logic        sy;
      logic signed [65:0] ex;
      logic signed [65:0] ey;
      logic signed [65:0] p;
      sx = (o == 2'b01) || (o == 2'b10);
      sy = (o == 2'b01);
      ex = {{34{sx & x[31]}}, x};
      ey = {{34{sy & y[31]}}, y};
      p  = ex * ey;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("busy", 32'(busy), 32'(m_busy));
         check("in_ready", 32'(in_ready), 32'(!m_busy));
         if (m_ov) check("result", result, m_res);
      end
   end

   // Called #1 after an edge with the DUT idle; returns #1 after the
   // release edge, so a following call is accepted on the very next edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold, output logic [31:0] got);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = 1'b0;
      @(posedge clk);
      m_busy = 1'b1;
      m_res  = ref_mul(o, x, y);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      op       = 2'($urandom_range(0, 3));
      repeat (34) @(posedge clk);
      m_ov = 1'b1;
      #1;
      got = result;
      repeat (hold) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      m_ov   = 1'b0;
      m_busy = 1'b0;
      #1;
      out_ready = 1'b0;
      $display("op=%0d a=0x%08h b=0x%08h hold=%0d result=0x%08h expect=0x%08h",
               o, x, y, hold, got, ref_mul(o, x, y));
   endtask

   // Abort an operation on the n-th edge after acceptance, by flush or reset.
   task automatic abort_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int n, input logic use_rst);
      in_valid = 1'b1;
      op       = o;
      a        = x;
      b        = y;
      @(posedge clk);
      m_busy = 1'b1;
      #1;
      in_valid = 1'b0;
      repeat (n - 1) @(posedge clk);
      #1;
      if (use_rst) rst_n = 1'b0;
      else         flush = 1'b1;
      @(posedge clk);
      m_busy = 1'b0;
      m_ov   = 1'b0;
      #1;
      rst_n = 1'b1;
      flush = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      $display("abort op=%0d a=0x%08h b=0x%08h at edge %0d by %s", o, x, y, n,
               use_rst ? "reset" : "flush");
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [6];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF;
      corners[5] = 32'h8000_0001;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] got;

      // Pin the reference model with hand-computed products.
      check("ref mul 7x6", ref_mul(2'b00, 32'd7, 32'd6), 32'h0000_002A);
      check("ref mulh min*min", ref_mul(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      check("ref mulhsu -1*max", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
      check("ref mulhu max*max", ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", result, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      mon_en = 1'b1;

      run_op(2'b00, 32'd7, 32'd6, 0, got);
      check("mul 7x6", got, 32'h0000_002A);
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1, got);
      check("mulh min*min", got, 32'h4000_0000);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, got);
      check("mul min*min", got, 32'h0000_0000);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, got);
      check("mulhsu -1*max", got, 32'hFFFF_FFFF);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, got);
      check("mulhu max*max", got, 32'hFFFF_FFFE);
      run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, got);
      check("mulh -3*5", got, 32'hFFFF_FFFF);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 10, got);
      check("mul -3*5 held", got, 32'hFFFF_FFF1);

      abort_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 15, 1'b0);
      abort_op(2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 20, 1'b1);
      run_op(2'b00, 32'd3, 32'd3, 0, got);
      check("mul 3x3 after abort", got, 32'd9);

      // flush together with in_valid in IDLE must not start an operation.
      in_valid = 1'b1;
      flush    = 1'b1;
      op       = 2'b11;
      a        = 32'd5;
      b        = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("flush+in_valid busy", 32'(busy), 32'd0);

      for (int i = 0; i < 30; i++) begin
         logic [1:0]  o;
         logic [31:0] x;
         logic [31:0] y;
         o = 2'($urandom_range(0, 3));
         x = pick_operand();
         y = pick_operand();
         run_op(o, x, y, $urandom_range(0, 3), got);
         check("random result", got, ref_mul(o, x, y));
         if (i % 8 == 7) begin
            abort_op(2'($urandom_range(0, 3)), $urandom, $urandom,
                     $urandom_range(1, 33), 1'($urandom_range(0, 1)));
         end
      end

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_iter_32.md
Name: mul_iter_32

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
- Sits in the ALU submodule set, upstream of writeback. It drives a 32-bit carry-lookahead adder every cycle.
- Takes operands through a valid/ready handshake, runs 32 add/shift iterations plus one sign-fix cycle, then holds the 32-bit result until the consumer accepts it.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands and op are valid.
in_ready  output  1  block can accept; high only in IDLE.
op  input  2  00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
a  input  XLEN  rs1 operand.
b  input  XLEN  rs2 operand.
flush  input  1  abort any in-flight operation.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  XLEN  selected product half.
busy  output  1  high in CALC, FIX or DONE.

Behaviour:
- Reset: when rst_n is low at an edge, state=IDLE. Registered outputs out_valid=0, result=0, busy=0; in_ready=1 (combinational, high in IDLE). Counter and datapath registers are cleared. A reset mid-operation discards the operation, with no output.
- States and transitions:
  - IDLE → CALC on in_valid&in_ready.
  - CALC → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
- Accept edge: the block latches op and neg = sign(a_eff) XOR sign(b_eff).
  - a is signed for op 01/10; b is signed for op 01 only. op 00 treats both as unsigned; the low half is sign-independent.
  - It latches the magnitudes |a|, |b| as 32-bit unsigned. |−2^31| = 0x8000_0000.
  - It sets acc_hi=0 (33 bits), mplr=|b|, cnt=0.
- CALC, each edge:
  - sum = acc_hi + (mplr[0] ? |a| : 0), computed by the adder sub-module with carry-in 0 and a 33-bit result.
  - Then {acc_hi, mplr} = {sum, mplr} >> 1 (logical), and cnt++.
  - Leave CALC when cnt reaches 31 at that edge, i.e. exactly 32 CALC cycles.
- FIX: the 64-bit product P={acc_hi[31:0], mplr}. If neg, P = ~P + 1, using the adder sub-module twice in sequence or a dedicated incrementer; either is fine provided it completes in this single cycle. The block registers result = op==00 ? P[31:0] : P[63:32].
- DONE: out_valid=1 with result stable. The block holds while out_ready=0. out_valid&out_ready at an edge → IDLE and out_valid=0. The block can accept again on the next edge (no same-cycle accept in DONE).
- Latency: handshake at edge k → out_valid first sampled high after edge k+34.
- flush: highest priority after reset. In any state it forces IDLE at the next edge, out_valid=0, and no result is delivered. flush coincident with in_valid in IDLE: the operation is not accepted.
- in_valid while busy is ignored; the upstream stage must hold the request, and in_ready=0 makes this explicit.
- No early termination on zero operands; latency is constant.

Decomposition:
- Shared package (alu_pkg):
  - mul op encodings MUL_OP_MUL/MULH/MULHSU/MULHU.
  - State enum MUL_IDLE/CALC/FIX/DONE.
  - XLEN constant.
- Sub-module add32_cla: 32-bit adder built from two 16-bit CLA blocks, ripple between halves, with carry-out. It yields the 33-bit sum, is instantiated once for the CALC accumulate, and is reused for the FIX negation or paired with a separate 64-bit incrementer.
- FSM, counter and datapath registers stay in mul_iter_32.

Test Plan:
1. op=00, a=7, b=6 → result 0x0000002A after exactly 34 edges; in_ready low throughout.
2. op=01, a=0x8000_0000, b=0x8000_0000 → result 0x4000_0000; op=00 same operands → 0x0000_0000.
3. op=10, a=0xFFFF_FFFF, b=0xFFFF_FFFF → result 0xFFFF_FFFF; op=11 same operands → 0xFFFF_FFFE.
4. op=01, a=0xFFFF_FFFD (−3), b=5 → result 0xFFFF_FFFF; op=00 → 0xFFFF_FFF1.
5. Hold out_ready=0 for 10 cycles after completion → out_valid and result stable. Raise out_ready → next edge IDLE; a new request is accepted on the following edge.
6. Assert flush at CALC cycle 15, and separately rst_n=0 at CALC cycle 20 → no out_valid. The next operation (a=3, b=3, op=00) returns 9 with the correct latency.
